tt_um_out_stream: RTL

- Return-path counterpart of the weight loader: the loader writes wide operand vectors in from the 16-bit input pins; this block reads a wide result vector out over the 8-bit output pins.
- Captures MAX_OUT_LEN signed results on a start pulse, then streams them byte-serially with a valid/ready handshake.
- Sits between the compute datapath and uo_out in the top level; the top-level FSM pulses start and waits for done.

---
 rtl/tt_um_out_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/tt_um_out_stream.sv
// Byte-serial result streamer: captures a vector of result words on a start
// pulse and shifts them out LSB-first over a valid/ready byte port.
// Optional header byte {4'hB, len} ahead of the data: define OUT_STREAM_HDR_EN.
module tt_um_out_stream #(
    parameter int MAX_OUT_LEN = 8,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic [$clog2(MAX_OUT_LEN)-1:0]     ui_len,
    input  logic [OUT_WIDTH*MAX_OUT_LEN-1:0]   ui_results,
    input  logic                               ui_ready,
    output logic [7:0]                         uo_data,
    output logic                               uo_valid,
    output logic                               uo_busy,
    output logic                               uo_done
);

    localparam int LEN_W = $clog2(MAX_OUT_LEN);
    localparam int BPW   = OUT_WIDTH / 8;
    localparam int BI_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int VEC_W = OUT_WIDTH * MAX_OUT_LEN;
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [VEC_W-1:0]  cap;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_idx;
    logic [BI_W-1:0]   byte_idx;
`ifdef OUT_STREAM_HDR_EN
    logic              hdr_pend;
`endif

    // cap[7:0] always mirrors the data byte on uo_data; each data transfer shifts it down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cap      <= '0;
            len_q    <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            uo_data  <= '0;
            uo_valid <= 1'b0;
            uo_busy  <= 1'b0;
            uo_done  <= 1'b0;
`ifdef OUT_STREAM_HDR_EN
            hdr_pend <= 1'b0;
`endif
        end else begin
            uo_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena) begin
                        cap      <= ui_results;
                        len_q    <= ui_len;
                        word_idx <= '0;
                        byte_idx <= '0;
                        uo_valid <= 1'b1;
                        uo_busy  <= 1'b1;
                        state    <= STREAM;
`ifdef OUT_STREAM_HDR_EN
                        uo_data  <= {4'hB, 4'(ui_len)};
                        hdr_pend <= 1'b1;
`else
                        uo_data  <= ui_results[7:0];
`endif
                    end
                end
                STREAM: begin
                    if (uo_valid && ui_ready) begin
`ifdef OUT_STREAM_HDR_EN
                        if (hdr_pend) begin
                            hdr_pend <= 1'b0;
                            uo_data  <= cap[7:0];
                        end else
`endif
                        if (word_idx == len_q && byte_idx == LAST_BYTE) begin
                            uo_valid <= 1'b0;
                            uo_busy  <= 1'b0;
                            uo_done  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cap     <= cap >> 8;
                            uo_data <= cap[15:8];
                            if (byte_idx == LAST_BYTE) begin
                                byte_idx <= '0;
                                word_idx <= word_idx + LEN_W'(1);
                            end else begin
                                byte_idx <= byte_idx + BI_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    uo_valid <= 1'b0;
                    uo_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
